// File: rtl/btn_pkg.sv
// Shared types and default timing constants for the pushbutton debounce bank.
// Defaults assume a 1 ms sample strobe.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    HOLD_WAIT = 2'd1,
    REPEAT    = 2'd2
  } rpt_state_e;

  localparam int DEF_NUM_BTN   = 5;
  localparam int DEF_DEPTH     = 10;
  localparam int DEF_RPT_DELAY = 500;
  localparam int DEF_RPT_RATE  = 100;
  localparam int DEF_CNT_W     = 10;

endpackage

// File: rtl/btn_debounce_chan.sv
// One button channel: 2-flop synchroniser, sampled history with hysteresis,
// registered press/release strobes and an auto-repeat FSM.
//   state     | meaning
//   IDLE      | button released, waiting for a debounced press
//   HOLD_WAIT | held, counting samples up to the first repeat
//   REPEAT    | held, strobing every RPT_RATE samples
module btn_debounce_chan
  import btn_pkg::*;
#(
  parameter int DEPTH     = DEF_DEPTH,
  parameter int RPT_DELAY = DEF_RPT_DELAY,
  parameter int RPT_RATE  = DEF_RPT_RATE,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic sample_en,
  input  logic btn_raw,
  input  logic rpt_en,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_repeat
);

  localparam logic [CNT_W-1:0] DLY_LAST  = CNT_W'(RPT_DELAY - 1);
  localparam logic [CNT_W-1:0] RATE_LAST = CNT_W'(RPT_RATE - 1);

  logic             sync1_q, sync1_d, sync2_q, sync2_d;
  logic [DEPTH-1:0] hist_q, hist_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             repeat_q, repeat_d;
  rpt_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             all_ones, all_zeros, fall_now;

  always_comb begin
    sync1_d   = btn_raw;
    sync2_d   = sync1_q;
    hist_d    = sample_en ? {hist_q[DEPTH-2:0], sync2_q} : hist_q;
    all_ones  = &hist_q;
    all_zeros = ~|hist_q;
    level_d   = level_q;
    if (all_ones) begin
      level_d = 1'b1;
    end else if (all_zeros) begin
      level_d = 1'b0;
    end
    press_d   = all_ones & ~level_q;
    release_d = all_zeros & level_q;
    // A release is already certain once the incoming history is all zeros,
    // so a repeat due on that same sample is dropped.
    fall_now  = level_q & ~|hist_d;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    repeat_d = 1'b0;
    if (fall_now) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (press_d) begin
            state_d = HOLD_WAIT;
            cnt_d   = '0;
          end
        end
        HOLD_WAIT: begin
          if (sample_en && level_q) begin
            if (cnt_q == DLY_LAST) begin
              if (rpt_en) begin
                repeat_d = 1'b1;
                cnt_d    = '0;
                state_d  = REPEAT;
              end
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        REPEAT: begin
          if (sample_en && rpt_en) begin
            if (cnt_q == RATE_LAST) begin
              repeat_d = 1'b1;
              cnt_d    = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      hist_q    <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      repeat_q  <= 1'b0;
      state_q   <= IDLE;
      cnt_q     <= '0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      hist_q    <= hist_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      repeat_q  <= repeat_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
    end
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;
  assign btn_repeat  = repeat_q;

endmodule

// File: rtl/btn_debounce_bank.sv
// Bank of NUM_BTN independent debounced pushbutton channels sharing one
// external sample strobe.
module btn_debounce_bank
  import btn_pkg::*;
#(
  parameter int NUM_BTN   = DEF_NUM_BTN,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int RPT_DELAY = DEF_RPT_DELAY,
  parameter int RPT_RATE  = DEF_RPT_RATE,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sample_en,
  input  logic [NUM_BTN-1:0] btn_raw,
  input  logic [NUM_BTN-1:0] rpt_en,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic [NUM_BTN-1:0] btn_repeat
);

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
    btn_debounce_chan #(
      .DEPTH    (DEPTH),
      .RPT_DELAY(RPT_DELAY),
      .RPT_RATE (RPT_RATE),
      .CNT_W    (CNT_W)
    ) u_chan (
      .clk        (clk),
      .rst        (rst),
      .sample_en  (sample_en),
      .btn_raw    (btn_raw[i]),
      .rpt_en     (rpt_en[i]),
      .btn_level  (btn_level[i]),
      .btn_press  (btn_press[i]),
      .btn_release(btn_release[i]),
      .btn_repeat (btn_repeat[i])
    );
  end

endmodule

// File: tb/tb_btn_debounce_bank.sv
// Directed and randomized bench for btn_debounce_bank, compared every clock
// against a sample-run / held-sample-count reference model.
module tb_btn_debounce_bank;

  localparam int NB        = 5;
  localparam int DEPTH     = 4;
  localparam int RPT_DELAY = 3;
  localparam int RPT_RATE  = 2;
  localparam int CNT_W     = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          sample_en = 1'b0;
  logic [NB-1:0] btn_raw = '0;
  logic [NB-1:0] rpt_en = '0;
  logic [NB-1:0] btn_level, btn_press, btn_release, btn_repeat;

  btn_debounce_bank #(
    .NUM_BTN  (NB),
    .DEPTH    (DEPTH),
    .RPT_DELAY(RPT_DELAY),
    .RPT_RATE (RPT_RATE),
    .CNT_W    (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sample_en  (sample_en),
    .btn_raw    (btn_raw),
    .rpt_en     (rpt_en),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .btn_repeat (btn_repeat)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int sp       = 10;
  int phase    = 0;

  // Reference model: runs of identical samples, held-sample count since press.
  logic [NB-1:0] exp_level, exp_press, exp_release, exp_repeat;
  int   ones_run[NB], zeros_run[NB], held_k[NB];
  logic holding[NB], r1[NB], r2[NB];
  int   cnt_press[NB], cnt_release[NB], cnt_repeat[NB];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic model_reset();
    exp_level = '0; exp_press = '0; exp_release = '0; exp_repeat = '0;
    for (int c = 0; c < NB; c++) begin
      ones_run[c] = 0; zeros_run[c] = DEPTH; held_k[c] = 0;
      holding[c] = 1'b0; r1[c] = 1'b0; r2[c] = 1'b0;
    end
  endtask

  task automatic model_step();
    for (int c = 0; c < NB; c++) begin
      logic samp, lvl_pre, hold_pre;
      samp     = r2[c];
      lvl_pre  = exp_level[c];
      hold_pre = holding[c];
      exp_press[c]   = (ones_run[c] >= DEPTH) && !lvl_pre;
      exp_release[c] = (zeros_run[c] >= DEPTH) && lvl_pre;
      exp_repeat[c]  = 1'b0;
      if (exp_press[c]) begin
        exp_level[c] = 1'b1; holding[c] = 1'b1; held_k[c] = 0;
      end
      if (exp_release[c]) begin
        exp_level[c] = 1'b0; holding[c] = 1'b0;
      end
      if (sample_en) begin
        if (samp) begin
          ones_run[c] = (ones_run[c] < DEPTH) ? ones_run[c] + 1 : DEPTH;
          zeros_run[c] = 0;
        end else begin
          zeros_run[c] = (zeros_run[c] < DEPTH) ? zeros_run[c] + 1 : DEPTH;
          ones_run[c] = 0;
        end
        if (hold_pre && lvl_pre && zeros_run[c] < DEPTH) begin
          held_k[c]++;
          if (rpt_en[c] && held_k[c] >= RPT_DELAY &&
              ((held_k[c] - RPT_DELAY) % RPT_RATE) == 0)
            exp_repeat[c] = 1'b1;
        end
      end
      r2[c] = r1[c];
      r1[c] = btn_raw[c];
    end
  endtask

  task automatic tick();
    sample_en = (phase == 0);
    phase = (phase + 1 >= sp) ? 0 : phase + 1;
    @(posedge clk);
    if (!rst) model_step();
    #1;
    chk("level",   32'(btn_level),   32'(exp_level));
    chk("press",   32'(btn_press),   32'(exp_press));
    chk("release", 32'(btn_release), 32'(exp_release));
    chk("repeat",  32'(btn_repeat),  32'(exp_repeat));
    for (int c = 0; c < NB; c++) begin
      cnt_press[c]   += int'(btn_press[c]);
      cnt_release[c] += int'(btn_release[c]);
      cnt_repeat[c]  += int'(btn_repeat[c]);
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clr_counts();
    for (int c = 0; c < NB; c++) begin
      cnt_press[c] = 0; cnt_release[c] = 0; cnt_repeat[c] = 0;
    end
  endtask

  task automatic wait_press(input int c, input int budget, input string tag);
    int i;
    i = 0;
    tick();
    while (!btn_press[c] && i < budget) begin
      tick();
      i++;
    end
    chk(tag, 32'(btn_press[c]), 32'd1);
  endtask

  initial begin
    int s;
    model_reset();
    clr_counts();
    #1 rst = 1'b1;
    #1;
    chk("rst_level",   32'(btn_level),   32'd0);
    chk("rst_press",   32'(btn_press),   32'd0);
    chk("rst_release", 32'(btn_release), 32'd0);
    chk("rst_repeat",  32'(btn_repeat),  32'd0);
    ticks(3);
    rst = 1'b0;
    ticks(20);

    // clean press on channel 0
    clr_counts();
    btn_raw[0] = 1'b1;
    ticks(80);
    chk("clean_press_cnt", 32'(cnt_press[0]), 32'd1);
    chk("clean_level", 32'(btn_level[0]), 32'd1);
    s = 0;
    for (int c = 1; c < NB; c++) s += cnt_press[c] + cnt_release[c] + cnt_repeat[c];
    chk("clean_others_quiet", 32'(s), 32'd0);

    // bounce on channel 1
    clr_counts();
    for (int i = 0; i < 20; i++) begin
      btn_raw[1] = ~btn_raw[1];
      ticks(3);
    end
    chk("bounce_no_press", 32'(cnt_press[1]), 32'd0);
    btn_raw[1] = 1'b1;
    ticks(80);
    chk("bounce_one_press", 32'(cnt_press[1]), 32'd1);

    // single glitch sample on held channel 0, then a real release
    clr_counts();
    btn_raw[0] = 1'b0;
    ticks(10);
    btn_raw[0] = 1'b1;
    ticks(60);
    chk("glitch_no_release", 32'(cnt_release[0]), 32'd0);
    chk("glitch_level", 32'(btn_level[0]), 32'd1);
    btn_raw[0] = 1'b0;
    ticks(80);
    chk("glitch_release", 32'(cnt_release[0]), 32'd1);
    chk("glitch_level_low", 32'(btn_level[0]), 32'd0);

    // auto-repeat on channel 2: 12 held samples -> repeats at 3,5,7,9,11
    rpt_en[2] = 1'b1;
    btn_raw[2] = 1'b1;
    wait_press(2, 200, "rpt_press_seen");
    clr_counts();
    ticks(120);
    chk("rpt_count", 32'(cnt_repeat[2]), 32'd5);
    btn_raw[2] = 1'b0;
    ticks(80);
    rpt_en[2] = 1'b0;
    btn_raw[2] = 1'b1;
    wait_press(2, 200, "norpt_press_seen");
    clr_counts();
    ticks(120);
    chk("norpt_count", 32'(cnt_repeat[2]), 32'd0);
    btn_raw[2] = 1'b0;
    ticks(80);

    // channel 3: final zero sample lands on repeat-due held sample 11
    rpt_en[3] = 1'b1;
    btn_raw[3] = 1'b1;
    wait_press(3, 200, "coinc_press_seen");
    clr_counts();
    ticks(70);
    btn_raw[3] = 1'b0;
    ticks(50);
    chk("coinc_release", 32'(cnt_release[3]), 32'd1);
    chk("coinc_repeat", 32'(cnt_repeat[3]), 32'd4);
    btn_raw[3] = 1'b1;
    wait_press(3, 200, "coinc_repress_seen");
    clr_counts();
    ticks(40);
    chk("coinc_idle_first_rpt", 32'(cnt_repeat[3]), 32'd1);
    btn_raw[3] = 1'b0;
    ticks(80);
    rpt_en[3] = 1'b0;

    // async reset between edges while channel 4 is repeating
    rpt_en[4] = 1'b1;
    btn_raw[4] = 1'b1;
    wait_press(4, 200, "arst_press_seen");
    ticks(50);
    #3 rst = 1'b1;
    #1;
    chk("arst_level",   32'(btn_level),   32'd0);
    chk("arst_press",   32'(btn_press),   32'd0);
    chk("arst_release", 32'(btn_release), 32'd0);
    chk("arst_repeat",  32'(btn_repeat),  32'd0);
    model_reset();
    ticks(3);
    rst = 1'b0;
    clr_counts();
    wait_press(4, 100, "arst_fresh_press");
    chk("arst_fresh_press_cnt", 32'(cnt_press[4]), 32'd1);

    // randomized phase: all channels released first, rpt_en fixed per run
    btn_raw = '0;
    ticks(100);
    rpt_en = NB'($urandom);
    sp = 5;
    phase = 0;
    for (int i = 0; i < 2000; i++) begin
      for (int c = 0; c < NB; c++)
        if ($urandom_range(0, 39) == 0) btn_raw[c] = ~btn_raw[c];
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
